// File: rtl/writeback_trace_buffer.sv
// writeback_trace_buffer: circular log of retired register-file writes.
// Each entry holds the PC, the write data and a 16-bit sequence number.
// Ports:
//   in:  Clk, Reset, ProgramCount, WriteData, RegWriteCommand, Freeze, RdReq
//   out: RdValid, RdPC, RdData, RdSeq, Count, Full, Overflow
module writeback_trace_buffer #(
  parameter int DEPTH            = 16,
  parameter int ADDR_W           = 4,
  parameter bit OVERWRITE_OLDEST = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       ProgramCount,
  input  logic [31:0]       WriteData,
  input  logic              RegWriteCommand,
  input  logic              Freeze,
  input  logic              RdReq,
  output logic              RdValid,
  output logic [31:0]       RdPC,
  output logic [31:0]       RdData,
  output logic [15:0]       RdSeq,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Overflow
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  logic [31:0] pcMem   [DEPTH];
  logic [31:0] dataMem [DEPTH];
  logic [15:0] seqMem  [DEPTH];

  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W:0]   count;
  logic [15:0]       seqCnt;
  logic              overflow;

  logic capture;
  logic isFull;
  logic isEmpty;
  logic pop;
  logic push;
  logic overwrite;
  logic dropCap;
  logic writeEn;

  always_comb begin
    capture   = RegWriteCommand & ~Freeze;
    isFull    = (count == FullCount);
    isEmpty   = (count == '0);
    pop       = RdReq & ~isEmpty;
    // A pop in the same cycle frees the slot, so a full
    // buffer can still accept the capture.
    push      = capture & (~isFull | pop);
    overwrite = capture & isFull & ~pop & OVERWRITE_OLDEST;
    dropCap   = capture & isFull & ~pop & ~OVERWRITE_OLDEST;
    writeEn   = push | overwrite;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      seqCnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (writeEn)
        wrPtr <= wrPtr + PtrOne;
      // Overwrite retires the oldest entry, so head moves too.
      if (pop | overwrite)
        rdPtr <= rdPtr + PtrOne;
      if (push && !pop)
        count <= count + CountOne;
      else if (pop && !push)
        count <= count - CountOne;
      if (capture)
        seqCnt <= seqCnt + 16'd1;
      if (overwrite | dropCap)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (writeEn && !Reset) begin
      pcMem[wrPtr]   <= ProgramCount;
      dataMem[wrPtr] <= WriteData;
      seqMem[wrPtr]  <= seqCnt;
    end
  end

  always_comb begin
    RdValid  = ~isEmpty;
    RdPC     = isEmpty ? '0 : pcMem[rdPtr];
    RdData   = isEmpty ? '0 : dataMem[rdPtr];
    RdSeq    = isEmpty ? '0 : seqMem[rdPtr];
    Count    = count;
    Full     = isFull;
    Overflow = overflow;
  end

endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Testbench for writeback_trace_buffer: drop and overwrite variants
// driven in lockstep, checked against a queue-based scoreboard.
module tb_writeback_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wd;
    logic [15:0] seq;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ProgramCount;
  logic [31:0] WriteData;
  logic        RegWriteCommand;
  logic        Freeze;
  logic        RdReq;

  logic        RdValid0, RdValid1;
  logic [31:0] RdPC0, RdPC1;
  logic [31:0] RdData0, RdData1;
  logic [15:0] RdSeq0, RdSeq1;
  logic [4:0]  Count0, Count1;
  logic        Full0, Full1;
  logic        Overflow0, Overflow1;

  ent_t        sb0[$];
  ent_t        sb1[$];
  logic [15:0] seqM;
  logic        ovf0, ovf1;

  int nTests = 0;
  int nFail  = 0;

  always #5 Clk = ~Clk;

  writeback_trace_buffer #(
    .DEPTH(16), .ADDR_W(4), .OVERWRITE_OLDEST(1'b0)
  ) dut0 (
    .Clk(Clk), .Reset(Reset),
    .ProgramCount(ProgramCount), .WriteData(WriteData),
    .RegWriteCommand(RegWriteCommand), .Freeze(Freeze),
    .RdReq(RdReq), .RdValid(RdValid0), .RdPC(RdPC0),
    .RdData(RdData0), .RdSeq(RdSeq0), .Count(Count0),
    .Full(Full0), .Overflow(Overflow0)
  );

  writeback_trace_buffer #(
    .DEPTH(16), .ADDR_W(4), .OVERWRITE_OLDEST(1'b1)
  ) dut1 (
    .Clk(Clk), .Reset(Reset),
    .ProgramCount(ProgramCount), .WriteData(WriteData),
    .RegWriteCommand(RegWriteCommand), .Freeze(Freeze),
    .RdReq(RdReq), .RdValid(RdValid1), .RdPC(RdPC1),
    .RdData(RdData1), .RdSeq(RdSeq1), .Count(Count1),
    .Full(Full1), .Overflow(Overflow1)
  );

  // Drive one cycle, update the scoreboard at the edge,
  // return 1 time unit after the edge with inputs idle.
  task automatic step(input logic wr, input logic [31:0] pc,
                      input logic [31:0] wd, input logic rd,
                      input logic frz, input logic rst);
    ent_t e;
    logic cap;
    RegWriteCommand = wr;
    ProgramCount    = pc;
    WriteData       = wd;
    RdReq           = rd;
    Freeze          = frz;
    Reset           = rst;
    @(posedge Clk);
    if (rst) begin
      sb0.delete();
      sb1.delete();
      seqM = 16'd0;
      ovf0 = 1'b0;
      ovf1 = 1'b0;
    end else begin
      cap = wr & ~frz;
      if (rd && sb0.size() > 0) void'(sb0.pop_front());
      if (rd && sb1.size() > 0) void'(sb1.pop_front());
      if (cap) begin
        e = '{pc: pc, wd: wd, seq: seqM};
        if (sb0.size() < DEPTH) sb0.push_back(e);
        else ovf0 = 1'b1;
        if (sb1.size() < DEPTH) sb1.push_back(e);
        else begin
          ovf1 = 1'b1;
          void'(sb1.pop_front());
          sb1.push_back(e);
        end
        seqM = seqM + 16'd1;
      end
    end
    #1;
    RegWriteCommand = 1'b0;
    ProgramCount    = '0;
    WriteData       = '0;
    RdReq           = 1'b0;
    Freeze          = 1'b0;
    Reset           = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    nTests++;
    if ({RdValid0, Full0, Overflow0, Count0} !== 8'h00) begin
      nFail++;
      $display("FAIL reset_flags got v=%b f=%b o=%b c=%0d exp 0",
               RdValid0, Full0, Overflow0, Count0);
    end
    nTests++;
    if ({RdPC0, RdData0, RdSeq0} !== 80'h0) begin
      nFail++;
      $display("FAIL reset_head got %h %h %h exp 0",
               RdPC0, RdData0, RdSeq0);
    end
    nTests++;
    if ({RdValid1, Count1, Overflow1} !== 7'h00) begin
      nFail++;
      $display("FAIL reset_dut1 got v=%b c=%0d o=%b exp 0",
               RdValid1, Count1, Overflow1);
    end
  endtask

  task automatic test_single;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h10, 32'hAB, 1'b0, 1'b0, 1'b0);
    nTests++;
    if ({RdValid0, RdPC0, RdData0, RdSeq0, Count0} !==
        {1'b1, 32'h10, 32'hAB, 16'h0, 5'd1}) begin
      nFail++;
      $display("FAIL single got v=%b pc=%h d=%h s=%0d c=%0d",
               RdValid0, RdPC0, RdData0, RdSeq0, Count0);
    end
  endtask

  task automatic test_overflow;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    fill(17);
    nTests++;
    if ({Full0, Count0, Overflow0} !== {1'b1, 5'd16, ovf0}
        || !ovf0) begin
      nFail++;
      $display("FAIL ovf_drop got f=%b c=%0d o=%b exp 1 16 1",
               Full0, Count0, Overflow0);
    end
    nTests++;
    if ({Full1, Count1, Overflow1, RdSeq1} !==
        {1'b1, 5'd16, 1'b1, 16'd1}) begin
      nFail++;
      $display("FAIL ovf_owr got f=%b c=%0d o=%b s=%0d exp 1 16 1 1",
               Full1, Count1, Overflow1, RdSeq1);
    end
    for (int i = 0; i < 16; i++) begin
      nTests++;
      if (sb0.size() == 0 || sb1.size() == 0) begin
        nFail++;
        $display("FAIL drain_sb empty at %0d", i);
      end else if ({RdPC0, RdData0, RdSeq0} !== sb0[0]
          || RdSeq0 !== 16'(i)
          || {RdPC1, RdData1, RdSeq1} !== sb1[0]
          || RdSeq1 !== 16'(i + 1)) begin
        nFail++;
        $display("FAIL drain[%0d] got s0=%0d s1=%0d pc0=%h exp s0=%0d s1=%0d pc0=%h",
                 i, RdSeq0, RdSeq1, RdPC0, sb0[0].seq,
                 sb1[0].seq, sb0[0].pc);
      end
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end
    nTests++;
    if ({RdValid0, Count0, RdValid1, Count1} !== 12'h0) begin
      nFail++;
      $display("FAIL drained got c0=%0d c1=%0d exp 0", Count0, Count1);
    end
    step(1'b1, 32'h200, 32'h300, 1'b0, 1'b0, 1'b0);
    nTests++;
    if (RdSeq0 !== 16'd17 || RdSeq1 !== 16'd17) begin
      nFail++;
      $display("FAIL seq_gap got s0=%0d s1=%0d exp 17",
               RdSeq0, RdSeq1);
    end
  endtask

  task automatic test_full_pushpop;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    fill(16);
    step(1'b1, 32'hCAFE, 32'hF00D, 1'b1, 1'b0, 1'b0);
    nTests++;
    if ({Count0, Overflow0, RdSeq0, Full0} !==
        {5'd16, 1'b0, 16'd1, 1'b1}) begin
      nFail++;
      $display("FAIL full_pp got c=%0d o=%b s=%0d exp 16 0 1",
               Count0, Overflow0, RdSeq0);
    end
    nTests++;
    if ({Count1, Overflow1, RdSeq1} !== {5'd16, 1'b0, 16'd1}) begin
      nFail++;
      $display("FAIL full_pp1 got c=%0d o=%b s=%0d exp 16 0 1",
               Count1, Overflow1, RdSeq1);
    end
  endtask

  task automatic test_freeze;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h44, 32'h55, 1'b0, 1'b1, 1'b0);
    nTests++;
    if (Count0 !== 5'd0) begin
      nFail++;
      $display("FAIL frozen got c=%0d exp 0", Count0);
    end
    step(1'b1, 32'h44, 32'h55, 1'b0, 1'b0, 1'b0);
    nTests++;
    if (Count0 !== 5'd1 || RdSeq0 !== 16'd0 || RdPC0 !== 32'h44) begin
      nFail++;
      $display("FAIL unfreeze got c=%0d s=%0d exp 1 0",
               Count0, RdSeq0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    nTests++;
    if (Count0 !== 5'd0) begin
      nFail++;
      $display("FAIL frz_pop got c=%0d exp 0", Count0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    nTests++;
    if (Count0 !== 5'd0 || RdValid0 !== 1'b0) begin
      nFail++;
      $display("FAIL empty_pop got c=%0d v=%b exp 0 0",
               Count0, RdValid0);
    end
  endtask

  task automatic test_empty_cap_pop;
    step(1'b1, 32'h77, 32'h88, 1'b1, 1'b0, 1'b0);
    nTests++;
    if (Count0 !== 5'd1 || sb0.size() != 1
        || {RdPC0, RdData0, RdSeq0} !== sb0[0]) begin
      nFail++;
      $display("FAIL empty_cp got c=%0d pc=%h s=%0d exp 1 77 1",
               Count0, RdPC0, RdSeq0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      nTests++;
      if (sb0.size() == 0) begin
        nFail++;
        $display("FAIL b2b_sb empty at %0d", i);
      end else if (Count0 !== 5'd1
          || {RdPC0, RdData0, RdSeq0} !== sb0[0]) begin
        nFail++;
        $display("FAIL b2b[%0d] got c=%0d pc=%h d=%h s=%0d exp pc=%h d=%h s=%0d",
                 i, Count0, RdPC0, RdData0, RdSeq0,
                 sb0[0].pc, sb0[0].wd, sb0[0].seq);
      end
    end
  endtask

  task automatic test_reset_mid;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    fill(17);
    for (int i = 0; i < 11; i++)
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    nTests++;
    if (Count0 !== 5'd5 || Overflow0 !== 1'b1) begin
      nFail++;
      $display("FAIL pre_rst got c=%0d o=%b exp 5 1",
               Count0, Overflow0);
    end
    step(1'b1, 32'h99, 32'h99, 1'b1, 1'b0, 1'b1);
    nTests++;
    if ({Count0, RdValid0, Overflow0, Overflow1, RdPC0} !==
        {5'd0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      nFail++;
      $display("FAIL mid_rst got c=%0d v=%b o0=%b o1=%b exp 0",
               Count0, RdValid0, Overflow0, Overflow1);
    end
    step(1'b1, 32'h123, 32'h456, 1'b0, 1'b0, 1'b0);
    nTests++;
    if (RdSeq0 !== 16'd0 || RdSeq1 !== 16'd0 || Count0 !== 5'd1) begin
      nFail++;
      $display("FAIL post_rst got s0=%0d s1=%0d c=%0d exp 0 0 1",
               RdSeq0, RdSeq1, Count0);
    end
  endtask

  initial begin
    Reset           = 1'b1;
    ProgramCount    = '0;
    WriteData       = '0;
    RegWriteCommand = 1'b0;
    Freeze          = 1'b0;
    RdReq           = 1'b0;
    seqM            = '0;
    ovf0            = 1'b0;
    ovf1            = 1'b0;
    @(negedge Clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_freeze();
    test_empty_cap_pop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/writeback_trace_buffer.md
Name: writeback_trace_buffer

Overview:
- Debug capture block directly downstream of the pipelined datapath top level.
- Consumes the retired-write observation outputs: ProgramCount, WriteData and RegWriteCommand.
- Logs every register-file write into a circular buffer, tagging each entry with a sequence number.
- Presents the oldest entry on a valid/ready style read port, for a display sequencer or a testbench scoreboard to drain.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- OVERWRITE_OLDEST, 0: 0 drops the new entry when full; 1 overwrites the oldest entry when full.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ProgramCount  input  32  PC value from the datapath, sampled with each write.
- WriteData  input  32  write-back data from the datapath.
- RegWriteCommand  input  1  write-back strobe from the datapath; 1 = capture this cycle.
- Freeze  input  1  1 = capture disabled; the strobe is ignored and the sequence number is not advanced.
- RdReq  input  1  consumer pop request; honoured only while RdValid = 1.
- RdValid  output  1  1 while the buffer holds at least one entry.
- RdPC  output  32  ProgramCount of the head entry.
- RdData  output  32  WriteData of the head entry.
- RdSeq  output  16  sequence number of the head entry.
- Count  output  ADDR_W+1  number of entries held, 0..DEPTH.
- Full  output  1  Count == DEPTH.
- Overflow  output  1  sticky; set on any write lost or overwritten.

Behaviour:
- Reset (synchronous, takes priority over all other inputs):
  - Write pointer, read pointer, Count, sequence counter and Overflow go to 0.
  - Outputs after the reset edge: RdValid = 0, Full = 0, RdPC = RdData = RdSeq = 0.
  - Memory contents become don't-care.
  - A reset asserted mid-drain discards all entries; a pop or capture requested in the same cycle as Reset is ignored.
- Capture event:
  - Capture = RegWriteCommand & ~Freeze, sampled at the rising edge.
  - The entry {ProgramCount, WriteData, seq} is stored at the write pointer.
  - The entry is visible on the read port the cycle after that edge (1-cycle latency when the buffer was empty).
- Sequence counter:
  - 16-bit; increments on every capture event, including dropped ones.
  - A stored entry carries the counter value before the increment.
  - Wraps from 0xFFFF to 0x0000.
  - A gap in RdSeq marks lost writes.
- Read port:
  - First-word-fall-through: RdPC, RdData and RdSeq show the head entry whenever Count > 0, and are forced to 0 when Count == 0.
  - Pop = RdReq & RdValid. The read pointer advances at the edge and the next entry appears the following cycle.
  - RdReq while empty has no effect.
- Pointers wrap modulo DEPTH.
- Count:
  - +1 on push without pop.
  - -1 on pop without push.
  - Unchanged on simultaneous push and pop.
- Boundary cases:
  - Full, capture and pop in the same cycle: both occur; Count stays at DEPTH; Overflow is not set.
  - Full, capture, no pop, OVERWRITE_OLDEST = 0: the entry is dropped; pointers and Count are unchanged; the sequence counter still increments; Overflow is set.
  - Full, capture, no pop, OVERWRITE_OLDEST = 1: the entry is written at the write pointer; both pointers advance; Count stays at DEPTH; Overflow is set. The head becomes the next-oldest entry.
  - Empty, capture and RdReq in the same cycle: the capture happens and the pop is ignored (RdValid was 0); Count becomes 1.
- Overflow clears only on Reset.
- Freeze has no effect on popping; draining continues while frozen.
- No combinational path from RdReq to any output.

Test Plan:
- Reset, then pulse RegWriteCommand with PC=0x10, WD=0xAB -> next cycle: RdValid=1, RdPC=0x10, RdData=0xAB, RdSeq=0, Count=1.
- 16 captures with RdReq=0 and OVERWRITE_OLDEST=0, then a 17th -> Full=1, Count=16, Overflow=1. Draining 16 entries yields RdSeq 0..15. A subsequent capture gets seq 17.
- Same sequence with OVERWRITE_OLDEST=1 -> Overflow=1, and the head after the 17th capture has RdSeq=1; draining yields seq 1..16.
- Full buffer with a capture and RdReq in the same cycle -> Count stays 16, Overflow=0, and the head advances by one.
- Freeze=1 during 3 write strobes, then Freeze=0 and one strobe -> Count=1, RdSeq=0. RdReq on an empty buffer leaves Count=0.
- Reset asserted with Count=5 together with a capture and RdReq -> next cycle: Count=0, RdValid=0, Overflow=0; the following capture stores seq 0.
